// File: rtl/tern_negate_stream_if.sv
// Stream bundle for tern_negate_stream.
// One input beat carries LANES signed elements plus one 2-bit ternary weight
// per lane. One output beat carries the LANES products, a per-lane overflow
// flag and an end-of-vector tag. The sticky reserved-code flag is on the same bundle.
//   slave  : the negation block (consumes in_*, produces out_*)
//   master : the environment driving inputs and consuming outputs
interface tern_negate_stream_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  logic                      in_valid;
  logic                      in_ready;
  logic [LANES*DATA_W-1:0]   in_data;
  logic [2*LANES-1:0]        in_wgt;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   out_data;
  logic [LANES-1:0]          out_sat;
  logic                      out_last;
  logic                      wgt_err;

  modport slave (
    input  in_valid, in_data, in_wgt, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_last, wgt_err
  );

  modport master (
    output in_valid, in_data, in_wgt, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_last, wgt_err
  );
endinterface

// File: rtl/tern_negate_stream.sv
// Ternary-weight multiply (0 / +1 / -1) over a stream of LANES-wide beats.
// Two-stage pipeline: stage 1 captures the beat, stage 2 holds the result.
// A beat counter tags the final beat of every VEC_LEN-element vector. The tag
// travels with the data and appears on out_last.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tern_negate_stream_if.slave
//           (in_valid/in_ready/in_data/in_wgt,
//            out_valid/out_ready/out_data/out_sat/out_last, wgt_err)
// Negating the most negative element overflows. SATURATE=1 clips the result
// to the maximum positive value. SATURATE=0 wraps it. In both cases out_sat
// flags the overflow.
module tern_negate_stream #(
  parameter int DATA_W   = 8,
  parameter int LANES    = 4,
  parameter int VEC_LEN  = 4096,
  parameter int SATURATE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tern_negate_stream_if.slave  bus
);

  localparam int W     = LANES * DATA_W;
  localparam int BEATS = VEC_LEN / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};

  // Negation with overflow handling; returns {overflow, value}.
  function automatic logic [DATA_W:0] neg_sat(input logic signed [DATA_W-1:0] x);
    if (x == SMIN) begin
      return {1'b1, (SATURATE != 0) ? SMAX : SMIN};
    end
    return {1'b0, -x};
  endfunction

  // Ternary product; the reserved code behaves like weight 0.
  function automatic logic [DATA_W:0] tern_lane(input logic signed [DATA_W-1:0] x,
                                                 input logic [1:0]              w);
    case (w)
      2'b01:   return {1'b0, x};
      2'b11:   return neg_sat(x);
      default: return '0;
    endcase
  endfunction

  logic                 vld_p1;
  logic                 last_p1;
  logic [W-1:0]         data_p1;
  logic [2*LANES-1:0]   wgt_p1;
  logic                 vld_p2;
  logic                 last_p2;
  logic [W-1:0]         data_p2;
  logic [LANES-1:0]     sat_p2;
  logic [CNT_W-1:0]     cnt;
  logic                 err;
  logic                 s2_adv;
  logic                 acc;
  logic                 rsv;
  logic [W-1:0]         res_p1;
  logic [LANES-1:0]     ovf_p1;

  assign s2_adv       = !vld_p2 | bus.out_ready;
  assign bus.in_ready = rst_n & (!vld_p1 | s2_adv);
  assign acc          = bus.in_valid & bus.in_ready;

  assign bus.out_valid = vld_p2;
  assign bus.out_data  = data_p2;
  assign bus.out_sat   = sat_p2;
  assign bus.out_last  = last_p2;
  assign bus.wgt_err   = err;

  always_comb begin
    rsv = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.in_wgt[2*i +: 2] == 2'b10) rsv = 1'b1;
    end
  end

  // ---- stage 1: capture accepted beat ----
  always_ff @(posedge clk) begin
    if (acc) begin
      data_p1 <= bus.in_data;
      wgt_p1  <= bus.in_wgt;
      last_p1 <= (cnt == CNT_LAST);
    end
  end

  always_comb begin
    logic [DATA_W:0] r;
    r      = '0;
    res_p1 = '0;
    ovf_p1 = '0;
    for (int i = 0; i < LANES; i++) begin
      r = tern_lane(data_p1[i*DATA_W +: DATA_W], wgt_p1[2*i +: 2]);
      ovf_p1[i]                   = r[DATA_W];
      res_p1[i*DATA_W +: DATA_W]  = r[DATA_W-1:0];
    end
  end

  // ---- stage 2: result register, control and counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      last_p2 <= 1'b0;
      data_p2 <= '0;
      sat_p2  <= '0;
      cnt     <= '0;
      err     <= 1'b0;
    end else begin
      if (bus.in_ready) vld_p1 <= bus.in_valid;
      if (s2_adv) begin
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= res_p1;
          sat_p2  <= ovf_p1;
          last_p2 <= last_p1;
        end
      end
      if (acc) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        if (rsv) err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/tern_negate_stream.md
TERN_NEGATE_STREAM -- requirements
Module: tern_negate_stream

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning signed element width in bits (minimum 2).
REQ-002 The module SHALL have parameter LANES, default 4, meaning elements processed per beat.
REQ-003 The module SHALL have parameter VEC_LEN, default 4096, meaning elements per vector; it SHALL be a multiple of LANES.
REQ-004 The module SHALL have parameter SATURATE, default 1, meaning 1 = clip negation overflow and 0 = two's-complement wrap.
REQ-005 Ports (name, direction, width, meaning):
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  module accepts beat this cycle.
- in_data  input  LANES*DATA_W  signed elements; lane i at bits [i*DATA_W +: DATA_W].
- in_wgt  input  2*LANES  ternary weight per lane at bits [2i+:2]: 2'b00 = 0, 2'b01 = +1, 2'b11 = -1, 2'b10 = reserved.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_data  output  LANES*DATA_W  signed products; same lane packing as in_data.
- out_sat  output  LANES  per-lane overflow flag for this beat.
- out_last  output  1  beat is the final beat of a vector.
- wgt_err  output  1  sticky flag: a reserved weight code was accepted.

Function
REQ-006 An input beat SHALL be accepted on a rising edge where in_valid and in_ready are both 1; an output beat SHALL be consumed where out_valid and out_ready are both 1.
REQ-007 The datapath SHALL be a two-stage register pipeline (S1 capture, S2 result); each stage holds at most one beat.
REQ-008 The ready chain SHALL be s2_adv = !s2_valid | out_ready and in_ready = !s1_valid | s2_adv; in_ready SHALL NOT depend on in_valid.
REQ-009 With out_ready held at 1, an accepted beat SHALL appear on out_valid/out_data exactly 2 cycles after acceptance, with throughput of one beat per cycle.
REQ-010 Under backpressure, S2 and S1 contents SHALL hold stable; no beat SHALL be dropped, duplicated or reordered; out_data SHALL NOT change while out_valid=1 and out_ready=0.
REQ-011 Per lane result: weight 0 or reserved gives 0; weight +1 gives x; weight -1 gives -x computed at DATA_W bits.
REQ-012 When weight is -1 and x = -2^(DATA_W-1), out_sat[i] SHALL be 1; the result SHALL be 2^(DATA_W-1)-1 if SATURATE=1, and -2^(DATA_W-1) (wrapped) if SATURATE=0.
REQ-013 In every other case out_sat[i] SHALL be 0.
REQ-014 A beat counter SHALL count accepted input beats from 0 to VEC_LEN/LANES-1 and then wrap to 0.
REQ-015 The beat accepted at counter value VEC_LEN/LANES-1 SHALL be tagged last; the tag SHALL travel with its data through the pipeline to out_last.
REQ-016 When VEC_LEN = LANES, every beat SHALL be tagged last.
REQ-017 wgt_err SHALL be set on acceptance of any beat containing a lane with code 2'b10 and SHALL clear only on reset.
REQ-018 Simultaneous accept at S1 and consume at S2 in the same cycle SHALL both take effect, with no bubble inserted.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously force: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_sat=0, out_last=0, wgt_err=0, beat counter=0.
REQ-020 While rst_n=0, in_ready SHALL be 0; after release, in_ready SHALL be 1 on the first cycle.
REQ-021 Reset asserted mid-vector SHALL discard all in-flight beats; the first beat accepted after reset SHALL count as beat 0 of a new vector.

Verification (DATA_W=8, LANES=4, VEC_LEN=8, SATURATE=1 unless noted)
REQ-022 Basic: in_data lanes {10,-11,127,5}, weights {+1,-1,-1,0}, out_ready=1 -> 2 cycles later out_data={10,11,-127,0}, out_sat=0000.
REQ-023 Overflow: lane0 = -128 with weight -1 -> SATURATE=1 gives 127 with out_sat[0]=1; SATURATE=0 gives -128 with out_sat[0]=1.
REQ-024 Streaming: 6 back-to-back beats with out_ready=1 -> 6 consecutive output cycles; out_last=1 on beats 2, 4 and 6 only.
REQ-025 Backpressure: random out_ready at 50% over 1000 beats -> output sequence equals scoreboard; out_data stable while stalled; in_ready falls only when both stages are full and out_ready=0.
REQ-026 Reserved code: one beat with weight 2'b10 -> that lane outputs 0 and wgt_err rises and stays 1 until rst_n=0.
REQ-027 Reset mid-vector: accept 1 beat, assert rst_n=0 with beats in flight -> outputs clear immediately; the next 2 accepted beats produce out_last on the second beat.
